// File: rtl/sram_bank_pkg.sv
// Shared types and sizes for the 2048x128 bank requester.
package sram_bank_pkg;

  localparam int unsigned BANK_DW    = 128;
  localparam int unsigned BANK_AW    = 11;
  localparam int unsigned BANK_LANES = 4;
  localparam int unsigned BANK_BW    = BANK_DW / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    INIT = 1'b1
  } init_state_t;

  typedef struct packed {
    logic [BANK_DW-1:0] rdata;
    logic               we;
    logic               err;
  } bank_rsp_t;

endpackage

// File: rtl/sram_bank_rsp_fifo.sv
// Small synchronous first-word-fall-through FIFO of bank responses.
module sram_bank_rsp_fifo
  import sram_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  bank_rsp_t wr_data,
  input  logic      pop,
  output bank_rsp_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  bank_rsp_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push_ok;
  logic            pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy do.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/sram_bank_initiator.sv
// Requester for the single-port bank: request stream to bank pins, read capture,
// credit-protected response FIFO and a post-boot zero-fill engine.
module sram_bank_initiator
  import sram_bank_pkg::*;
#(
  parameter int unsigned AW        = BANK_AW,
  parameter int unsigned DW        = BANK_DW,
  parameter int unsigned RSP_DEPTH = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [AW+1:0]   req_addr_i,
  input  logic            req_wide_i,
  input  logic            req_we_i,
  input  logic [DW/8-1:0] req_be_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_we_o,
  output logic            rsp_err_o,
  input  logic            init_start_i,
  output logic            init_busy_o,
  output logic            bank_en_o,
  output logic            bank_we_o,
  output logic            bank_narrow_o,
  output logic [AW+1:0]   bank_addr_o,
  output logic [DW/8-1:0] bank_be_o,
  output logic [DW-1:0]   bank_wdata_o,
  input  logic [DW-1:0]   bank_rdata_i
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  init_state_t   state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          cap_valid_q, cap_we_q, cap_err_q, cap_narrow_q;
  logic          issue;
  logic          req_err;
  logic          rsp_pop;
  logic          fifo_full, fifo_empty;
  bank_rsp_t     fifo_wr, fifo_rd;

  assign issue   = req_valid_i && ready_q;
  assign req_err = req_wide_i && (req_addr_i[1:0] != 2'b00);
  assign rsp_pop = rsp_valid_o && rsp_ready_i;

  // Credits cover in-flight captures plus FIFO occupancy.
  assign cnt_d   = cnt_q + CW'(issue) - CW'(rsp_pop);
  assign ready_d = (state_d == IDLE) && (cnt_d < CW'(RSP_DEPTH));

  // Next state and bank pin drive; pins follow the issue cycle combinationally.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    bank_en_o     = 1'b0;
    bank_we_o     = 1'b0;
    bank_narrow_o = 1'b0;
    bank_addr_o   = '0;
    bank_be_o     = '0;
    bank_wdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          bank_en_o     = 1'b1;
          bank_we_o     = req_we_i;
          bank_narrow_o = !req_wide_i;
          bank_addr_o   = req_wide_i ? {req_addr_i[AW+1:2], 2'b00} : req_addr_i;
          bank_be_o     = req_be_i;
          bank_wdata_o  = req_wdata_i;
        end
        if (init_start_i) begin
          state_d = INIT;
          row_d   = '0;
        end
      end
      INIT: begin
        bank_en_o   = 1'b1;
        bank_we_o   = 1'b1;
        bank_addr_o = {row_q, 2'b00};
        bank_be_o   = '1;
        row_d       = row_q + AW'(1);
        if (row_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_we_q     <= 1'b0;
      cap_err_q    <= 1'b0;
      cap_narrow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      cap_valid_q <= issue;
      if (issue) begin
        cap_we_q     <= req_we_i;
        cap_err_q    <= req_err;
        cap_narrow_q <= !req_wide_i;
      end
    end
  end

  // Capture stage: the bank answers one cycle after en; writes return no data.
  always_comb begin
    fifo_wr       = '0;
    fifo_wr.we    = cap_we_q;
    fifo_wr.err   = cap_err_q;
    if (!cap_we_q) begin
      fifo_wr.rdata = cap_narrow_q ? {{(DW-32){1'b0}}, bank_rdata_i[31:0]} : bank_rdata_i;
    end
  end

  sram_bank_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cap_valid_q),
    .wr_data(fifo_wr),
    .pop    (rsp_pop),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  cap_no_overflow: assert property (@(posedge clk) disable iff (rst)
    cap_valid_q |-> (!fifo_full || rsp_pop));

  assign req_ready_o = ready_q;
  assign init_busy_o = (state_q == INIT);
  assign rsp_valid_o = !fifo_empty;
  assign rsp_rdata_o = fifo_rd.rdata;
  assign rsp_we_o    = fifo_rd.we;
  assign rsp_err_o   = fifo_rd.err;

endmodule

// File: tb/tb_sram_bank_initiator.sv
// Randomized and directed bench for sram_bank_initiator with a memory-level reference.
module tb_sram_bank_initiator;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [12:0]  req_addr_i = '0;
  logic         req_wide_i = 1'b0;
  logic         req_we_i = 1'b0;
  logic [15:0]  req_be_i = '0;
  logic [127:0] req_wdata_i = '0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [127:0] rsp_rdata_o;
  logic         rsp_we_o;
  logic         rsp_err_o;
  logic         init_start_i = 1'b0;
  logic         init_busy_o;
  logic         bank_en_o, bank_we_o, bank_narrow_o;
  logic [12:0]  bank_addr_o;
  logic [15:0]  bank_be_o;
  logic [127:0] bank_wdata_o;
  logic [127:0] bank_rdata_i = '0;

  always #5 clk = ~clk;

  sram_bank_initiator dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_wide_i(req_wide_i), .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .init_start_i(init_start_i), .init_busy_o(init_busy_o),
    .bank_en_o(bank_en_o), .bank_we_o(bank_we_o), .bank_narrow_o(bank_narrow_o),
    .bank_addr_o(bank_addr_o), .bank_be_o(bank_be_o), .bank_wdata_o(bank_wdata_o),
    .bank_rdata_i(bank_rdata_i)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bank behaviour: byte-enabled writes, registered reads, narrow reads zero-extended.
  logic [127:0] bank_mem [2048];
  always @(posedge clk) begin : bank_model
    int r, l;
    if (bank_en_o) begin
      r = int'(bank_addr_o[12:2]);
      l = int'(bank_addr_o[1:0]);
      if (bank_we_o) begin
        if (bank_narrow_o) begin
          for (int i = 0; i < 4; i++)
            if (bank_be_o[i]) bank_mem[r][l*32+i*8 +: 8] <= bank_wdata_o[i*8 +: 8];
        end else begin
          for (int i = 0; i < 16; i++)
            if (bank_be_o[i]) bank_mem[r][i*8 +: 8] <= bank_wdata_o[i*8 +: 8];
        end
        bank_rdata_i <= {$urandom, $urandom, $urandom, $urandom};
      end else begin
        bank_rdata_i <= bank_mem[r];
        if (bank_narrow_o) bank_rdata_i <= {96'b0, bank_mem[r][l*32 +: 32]};
      end
    end
  end

  // Reference: memory image updated in request order plus a queue of expected responses.
  typedef struct packed {
    logic [127:0] rdata;
    logic         we;
    logic         err;
  } exp_rsp_t;

  logic [127:0] ref_mem [2048];
  exp_rsp_t     exp_q [$];
  int           init_rem = 0;
  int           since_rst = 0;
  logic         rst_prev = 1'b0;

  always @(negedge clk) begin : monitor
    exp_rsp_t e;
    int row, lane;
    logic in_init;
    logic [10:0] irow;
    logic [12:0] exp_addr;
    if (rst) begin
      if (!rst_prev && init_rem > 0) ref_mem[2048 - init_rem] = '0;
      if (rst_prev)
        check("reset_outputs", {req_ready_o, rsp_valid_o, init_busy_o, bank_en_o}, 4'b0000);
      exp_q.delete();
      init_rem  = 0;
      since_rst = 0;
    end else begin
      in_init = (init_rem > 0);
      check("req_ready", req_ready_o, (since_rst > 0) && !in_init && (exp_q.size() < 3));
      check("init_busy", init_busy_o, in_init);
      if (exp_q.size() == 0) begin
        check("no_rsp_expected", rsp_valid_o, 1'b0);
      end else if (rsp_valid_o && rsp_ready_i) begin
        e = exp_q.pop_front();
        check("rsp", {rsp_rdata_o, rsp_we_o, rsp_err_o}, {e.rdata, e.we, e.err});
      end
      if (in_init) begin
        irow = 11'(2048 - init_rem);
        check("init_pins", {bank_en_o, bank_we_o, bank_narrow_o, bank_addr_o, bank_be_o, bank_wdata_o},
              {3'b110, irow, 2'b00, 16'hFFFF, 128'b0});
        ref_mem[int'(irow)] = '0;
        init_rem--;
      end else if (req_valid_i && req_ready_o) begin
        row  = int'(req_addr_i[12:2]);
        lane = int'(req_addr_i[1:0]);
        exp_addr = req_wide_i ? {req_addr_i[12:2], 2'b00} : req_addr_i;
        check("issue_pins", {bank_en_o, bank_we_o, bank_narrow_o, bank_addr_o, bank_be_o, bank_wdata_o},
              {1'b1, req_we_i, !req_wide_i, exp_addr, req_be_i, req_wdata_i});
        e.we  = req_we_i;
        e.err = req_wide_i && (lane != 0);
        e.rdata = '0;
        if (req_we_i) begin
          for (int i = 0; i < 16; i++)
            if (req_wide_i && req_be_i[i]) ref_mem[row][i*8 +: 8] = req_wdata_i[i*8 +: 8];
          for (int i = 0; i < 4; i++)
            if (!req_wide_i && req_be_i[i]) ref_mem[row][lane*32+i*8 +: 8] = req_wdata_i[i*8 +: 8];
        end else begin
          e.rdata = req_wide_i ? ref_mem[row] : {96'b0, ref_mem[row][lane*32 +: 32]};
        end
        exp_q.push_back(e);
      end else begin
        check("bank_quiet", bank_en_o, 1'b0);
      end
      if (!in_init && init_start_i) init_rem = 2048;
      if (since_rst < 10) since_rst++;
    end
    rst_prev = rst;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int n);
    @(posedge clk); #1;
    rst = 1'b1; req_valid_i = 1'b0; init_start_i = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input logic [12:0] a, input logic wide, input logic we,
                       input logic [15:0] be, input logic [127:0] wd);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_addr_i = a; req_wide_i = wide; req_we_i = we; req_be_i = be; req_wdata_i = wd;
    req_valid_i = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1'b1; break; end
    end
    check("accept_in_time", ok, 1'b1);
    @(posedge clk); #1 req_valid_i = 1'b0;
  endtask

  task automatic read_rsp(input logic [12:0] a, input logic wide,
                          output logic [127:0] d, output logic err, output int lat);
    rsp_ready_i = 1'b1;
    issue(a, wide, 1'b0, 16'hFFFF, 128'b0);
    d = 'x; err = 1'bx; lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid_o) begin d = rsp_rdata_o; err = rsp_err_o; lat = k; break; end
    end
  endtask

  task automatic pulse_init();
    @(posedge clk); #1 init_start_i = 1'b1;
    @(posedge clk); #1 init_start_i = 1'b0;
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [127:0] d;
    logic         err, acc;
    int           lat, nacc, busy_cnt;
    logic [19:0]  vbits;

    for (int i = 0; i < 2048; i++) begin
      bank_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i]  = bank_mem[i];
    end
    reset_dut(3);
    idle(2);

    // Wide write then read with latency
    rsp_ready_i = 1'b1;
    issue({11'd5, 2'b00}, 1'b1, 1'b1, 16'hFFFF, 128'h0123456789ABCDEF_FEDCBA9876543210);
    idle(4);
    read_rsp({11'd5, 2'b00}, 1'b1, d, err, lat);
    check("wide_rd_latency", lat, 2);
    check("wide_rd_data", d, 128'h0123456789ABCDEF_FEDCBA9876543210);
    idle(3);

    // Narrow lane write then narrow and wide reads
    issue({11'd7, 2'b10}, 1'b0, 1'b1, 16'h000F, {96'b0, 32'hDEADBEEF});
    idle(4);
    read_rsp({11'd7, 2'b10}, 1'b0, d, err, lat);
    check("narrow_rd_data", d, {96'b0, 32'hDEADBEEF});
    idle(3);
    read_rsp({11'd7, 2'b00}, 1'b1, d, err, lat);
    check("wide_rd_lane2", d[95:64], 32'hDEADBEEF);
    idle(3);

    // Misaligned wide read
    read_rsp({11'd3, 2'b01}, 1'b1, d, err, lat);
    check("misaligned_err", err, 1'b1);
    idle(3);

    // Backpressure: only the credit depth is accepted
    rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    req_addr_i = {11'd9, 2'b01}; req_wide_i = 1'b0; req_we_i = 1'b0; req_valid_i = 1'b1;
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_valid_i && req_ready_o) nacc++;
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    check("bp_accepts", nacc, 3);
    @(negedge clk);
    check("bp_ready_low", req_ready_o, 1'b0);
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    idle(6);
    @(negedge clk);
    check("bp_ready_back", req_ready_o, 1'b1);

    // Streaming: one access per cycle
    idle(2);
    req_addr_i = {11'd12, 2'b00}; req_wide_i = 1'b1; req_we_i = 1'b0; req_valid_i = 1'b1;
    nacc = 0; vbits = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 16 && req_valid_i && req_ready_o) nacc++;
      vbits[k] = rsp_valid_o;
      @(posedge clk); #1;
      if (k == 15) req_valid_i = 1'b0;
    end
    check("stream_accepts", nacc, 16);
    check("stream_rsp_cycles", vbits, 20'h3FFFC);
    idle(3);

    // Randomized traffic against the reference
    acc = 1'b0;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk); #1;
      if (!req_valid_i || acc) begin
        req_valid_i = ($urandom_range(0, 3) != 0);
        req_addr_i  = {11'($urandom_range(0, 15)), 2'($urandom)};
        req_wide_i  = 1'($urandom);
        req_we_i    = 1'($urandom);
        req_be_i    = 16'($urandom);
        req_wdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = req_valid_i && req_ready_o;
    end
    @(posedge clk); #1 req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    idle(6);

    // Zero-fill with two responses pending
    rsp_ready_i = 1'b0;
    issue({11'd1, 2'b00}, 1'b1, 1'b0, 16'hFFFF, 128'b0);
    issue({11'd2, 2'b11}, 1'b0, 1'b0, 16'hFFFF, 128'b0);
    idle(2);
    rsp_ready_i = 1'b1;
    pulse_init();
    busy_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (init_busy_o) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    check("init_duration", busy_cnt, 2048);
    idle(2);
    for (int k = 0; k < 4; k++) begin
      read_rsp({11'($urandom_range(0, 15)), 2'b00}, 1'b1, d, err, lat);
      check("post_init_zero", d, 128'b0);
      idle(3);
    end

    // Reset in the middle of a zero-fill
    pulse_init();
    repeat (100) @(negedge clk);
    reset_dut(2);
    idle(2);
    check("mid_init_rst_busy", init_busy_o, 1'b0);
    check("mid_init_rst_ready", req_ready_o, 1'b1);
    read_rsp({11'd150, 2'b00}, 1'b1, d, err, lat);
    idle(3);
    read_rsp({11'd50, 2'b00}, 1'b1, d, err, lat);
    check("partial_init_zero", d, 128'b0);

    // Drain anything left
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
